// File: rtl/mips_cpu_bus_arbiter.sv
// Shares one Avalon-style slave between the MIPS instruction-fetch and data ports.
// Each grant latches the command, drives it to the slave and completes it back to its owner.
`timescale 1ns/1ps
module mips_cpu_bus_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter bit PRIORITY_DATA = 1'b1,
  parameter int WAIT_TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [3:0]            i_byteenable,
  output logic                  i_waitrequest,
  output logic [31:0]           i_readdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [3:0]            d_byteenable,
  input  logic [31:0]           d_writedata,
  output logic                  d_waitrequest,
  output logic [31:0]           d_readdata,
  output logic                  s_read,
  output logic                  s_write,
  output logic [ADDR_WIDTH-1:0] s_address,
  output logic [3:0]            s_byteenable,
  output logic [31:0]           s_writedata,
  input  logic                  s_waitrequest,
  input  logic [31:0]           s_readdata,
  output logic                  bus_error
);

  localparam int CW = ($clog2(WAIT_TIMEOUT + 1) > 8) ? $clog2(WAIT_TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_RESP} state_t;

  state_t                  state_q, state_d;
  logic                    owner_q, owner_d;   // 1 = data port
  logic                    rr_q, rr_d;         // 1 = data wins next contention
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    op_rd_q, op_rd_d;
  logic                    op_wr_q, op_wr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    abort_q, abort_d;
  logic                    err_pulse_q, err_pulse_d;
  logic                    bus_err_q, bus_err_d;

  logic d_legal, d_illegal, grant_sel;

  // The edge that ends an error pulse still sees the offending request; mask it.
  assign d_legal   = (d_read ^ d_write) && !err_pulse_q;
  assign d_illegal = d_read && d_write && !err_pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      rr_q        <= PRIORITY_DATA;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      op_rd_q     <= 1'b0;
      op_wr_q     <= 1'b0;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      op_rd_q     <= op_rd_d;
      op_wr_q     <= op_wr_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      err_pulse_q <= err_pulse_d;
      bus_err_q   <= bus_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    op_rd_d     = op_rd_q;
    op_wr_d     = op_wr_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    err_pulse_d = 1'b0;
    bus_err_d   = bus_err_q;
    grant_sel   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (d_illegal) begin
          bus_err_d   = 1'b1;
          err_pulse_d = 1'b1;
        end
        if (i_read || d_legal) begin
          grant_sel = (i_read && d_legal) ? rr_q : d_legal;
          if (i_read && d_legal) rr_d = ~rr_q;
          state_d = ST_CMD;
          owner_d = grant_sel;
          cnt_d   = '0;
          abort_d = 1'b0;
          if (grant_sel) begin
            addr_d  = d_address;
            be_d    = d_byteenable;
            wdata_d = d_writedata;
            op_rd_d = d_read;
            op_wr_d = d_write;
          end else begin
            addr_d  = i_address;
            be_d    = i_byteenable;
            wdata_d = '0;
            op_rd_d = 1'b1;
            op_wr_d = 1'b0;
          end
        end
      end
      ST_CMD: begin
        if (!s_waitrequest) begin
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_RESP;
          abort_d   = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_read        = (state_q == ST_CMD) && op_rd_q;
    s_write       = (state_q == ST_CMD) && op_wr_q;
    s_address     = addr_q;
    s_byteenable  = be_q;
    s_writedata   = wdata_q;
    bus_error     = bus_err_q;
    i_waitrequest = !((state_q == ST_RESP) && !owner_q);
    d_waitrequest = !(((state_q == ST_RESP) && owner_q) || err_pulse_q);
    i_readdata    = '0;
    d_readdata    = '0;
    // Aborted transfers and writes return zero; reads pass the slave data straight through.
    if ((state_q == ST_RESP) && op_rd_q && !abort_q) begin
      if (owner_q) d_readdata = s_readdata;
      else         i_readdata = s_readdata;
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Directed bench for mips_cpu_bus_arbiter: expectations queued at issue, checked by a monitor.
`timescale 1ns/1ps
module tb_mips_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_read;
  logic [31:0] i_address;
  logic [3:0]  i_byteenable;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic        d_read, d_write;
  logic [31:0] d_address;
  logic [3:0]  d_byteenable;
  logic [31:0] d_writedata;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic        s_read, s_write;
  logic [31:0] s_address;
  logic [3:0]  s_byteenable;
  logic [31:0] s_writedata;
  logic        s_waitrequest;
  logic [31:0] s_readdata = '0;
  logic        bus_error;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  // slave model
  logic [31:0] mem [0:255];
  bit          mem_init_done = 1'b0;
  int          cmd_cyc = 0;
  int          stall_n = 0;
  bit          stall_forever = 1'b0;

  mips_cpu_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_byteenable(i_byteenable),
    .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_byteenable(d_byteenable), .d_writedata(d_writedata),
    .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .s_read(s_read), .s_write(s_write), .s_address(s_address),
    .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  assign s_waitrequest = stall_forever || (cmd_cyc < stall_n);

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int k = 0; k < 256; k++) mem[k] <= '0;
      mem[4]  <= 32'h8C220004;
      mem[8]  <= 32'h11111111;
      mem[9]  <= 32'h22222222;
      mem[12] <= 32'h33333333;
      mem[13] <= 32'h44444444;
      mem_init_done <= 1'b1;
    end else begin
      if (s_read || s_write) cmd_cyc <= s_waitrequest ? cmd_cyc + 1 : 0;
      else                   cmd_cyc <= 0;
      if (s_write && !s_waitrequest) begin
        for (int b = 0; b < 4; b++)
          if (s_byteenable[b]) mem[s_address[9:2]][b*8 +: 8] <= s_writedata[b*8 +: 8];
      end
      if (s_read && !s_waitrequest) s_readdata <= mem[s_address[9:2]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic push_exp(input logic is_d, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // monitor: pops one expectation per completion
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (!i_waitrequest || !d_waitrequest)) begin
      exp_t e;
      if (!i_waitrequest && !d_waitrequest) begin
        check("single_owner", 32'(i_waitrequest | d_waitrequest), 32'd1);
      end else if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_completion: i_wr=%b d_wr=%b, required none", i_waitrequest, d_waitrequest);
      end else begin
        e = exp_q.pop_front();
        check("completion_port", 32'(!d_waitrequest), 32'(e.is_d));
        check("completion_data", d_waitrequest ? i_readdata : d_readdata, e.data);
      end
    end
  end

  task automatic wait_done(input bit is_d, input string name);
    bit done = 1'b0;
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge clk);
      if (is_d ? !d_waitrequest : !i_waitrequest) done = 1'b1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: no completion within 600 cycles, required completion", name);
    end
  endtask

  task automatic i_xfer(input logic [31:0] a);
    i_read = 1'b1; i_address = a; i_byteenable = 4'hF;
    wait_done(1'b0, "i_xfer");
    @(posedge clk); #1;
    i_read = 1'b0;
  endtask

  task automatic d_xfer(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
    d_read = rd; d_write = wr; d_address = a; d_byteenable = be; d_writedata = wd;
    wait_done(1'b1, "d_xfer");
    @(posedge clk); #1;
    d_read = 1'b0; d_write = 1'b0;
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (s_read || s_write) ok = 1'b1;
    end
    check("strobe_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0;
    i_read = 0; i_address = '0; i_byteenable = '0;
    d_read = 0; d_write = 0; d_address = '0; d_byteenable = '0; d_writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_i_wr", 32'(i_waitrequest), 32'd1);
    check("rst_d_wr", 32'(d_waitrequest), 32'd1);
    check("rst_strobes", 32'({s_read, s_write}), 32'd0);
    check("rst_s_addr", s_address, 32'd0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // lone fetch latency
    push_exp(1'b0, 32'h8C220004);
    i_read = 1'b1; i_address = 32'h10; i_byteenable = 4'hF;
    @(negedge clk); check("t1_pre_strobe", 32'(s_read), 32'd0);
    @(negedge clk); check("t1_s_read", 32'(s_read), 32'd1);
    check("t1_s_addr", s_address, 32'h10);
    @(negedge clk); check("t1_i_wr", 32'(i_waitrequest), 32'd0);
    @(posedge clk); #1; i_read = 1'b0;
    @(posedge clk); #1;

    // repeated contention alternates D,I,D,I
    push_exp(1'b1, 32'h11111111);
    push_exp(1'b0, 32'h33333333);
    push_exp(1'b1, 32'h22222222);
    push_exp(1'b0, 32'h44444444);
    fork
      begin d_xfer(1, 0, 32'h20, 4'hF, 0); d_xfer(1, 0, 32'h24, 4'hF, 0); end
      begin i_xfer(32'h30); i_xfer(32'h34); end
    join
    @(posedge clk); #1;

    // partial write then full readback
    push_exp(1'b1, 32'h0);
    fork
      d_xfer(0, 1, 32'h104, 4'b0011, 32'hAABBCCDD);
      begin
        wait_strobe(ok);
        check("t3_s_write", 32'({s_read, s_write}), 32'd1);
        check("t3_s_addr", s_address, 32'h104);
        check("t3_s_be", 32'(s_byteenable), 32'h3);
        check("t3_s_wdata", s_writedata, 32'hAABBCCDD);
      end
    join
    push_exp(1'b1, 32'h0000CCDD);
    d_xfer(1, 0, 32'h104, 4'hF, 0);

    // 3-cycle stall: command held stable, late master changes ignored
    stall_n = 3;
    push_exp(1'b1, 32'h11111111);
    fork
      d_xfer(1, 0, 32'h20, 4'hF, 0);
      begin
        wait_strobe(ok);
        d_address = 32'hFFC;
        for (int k = 0; k < 4; k++) begin
          if (k != 0) @(negedge clk);
          check("t4_stall_s_read", 32'(s_read), 32'd1);
          check("t4_stall_s_addr", s_address, 32'h20);
        end
        @(negedge clk);
        check("t4_resp_no_strobe", 32'(s_read), 32'd0);
      end
    join
    stall_n = 0;

    // stuck slave: watchdog abort
    check("t4_bus_error_before", 32'(bus_error), 32'd0);
    stall_forever = 1'b1;
    push_exp(1'b1, 32'h0);
    d_xfer(1, 0, 32'h24, 4'hF, 0);
    stall_forever = 1'b0;
    check("t4_bus_error_after", 32'(bus_error), 32'd1);

    // reset in the middle of CMD
    stall_forever = 1'b1;
    @(posedge clk); #1;
    i_read = 1'b1; i_address = 32'h10; i_byteenable = 4'hF;
    @(negedge clk); @(negedge clk);
    check("t6_in_cmd", 32'(s_read), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_strobe", 32'({s_read, s_write}), 32'd0);
    check("t6_rst_i_wr", 32'(i_waitrequest), 32'd1);
    check("t6_rst_s_addr", s_address, 32'd0);
    check("t6_rst_bus_error", 32'(bus_error), 32'd0);
    i_read = 1'b0;
    stall_forever = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_exp(1'b0, 32'h8C220004);
    i_xfer(32'h10);

    // illegal read+write request
    push_exp(1'b1, 32'h0);
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h40; d_byteenable = 4'hF; d_writedata = 32'h5;
    @(negedge clk);
    @(negedge clk);
    check("t5_d_wr_pulse", 32'(d_waitrequest), 32'd0);
    check("t5_no_strobe", 32'({s_read, s_write}), 32'd0);
    check("t5_bus_error", 32'(bus_error), 32'd1);
    @(posedge clk); #1;
    d_read = 1'b0; d_write = 1'b0;
    @(negedge clk);
    check("t5_pulse_len", 32'(d_waitrequest), 32'd1);
    check("t5_still_no_strobe", 32'({s_read, s_write}), 32'd0);

    repeat (3) @(posedge clk);
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule
